streaming_fixed_matmul: RTL and testbench

Handshaked, multi-cycle fixed-point matrix multiplier computing out = a @ b, with shapes (M,N) x (N,K) = (M,K).
- Operands are captured once, then accumulated over N cycles using M*K parallel signed MACs.
- Results are rounded or truncated to the output format and saturated.
- It sits between operand buffers and downstream quantisation/activation stages, and replaces purely combinational matmul use where N is large.

---
 rtl/streaming_fixed_matmul.sv | 193 +++++++++++++++++++
 tb/tb_streaming_fixed_matmul.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/streaming_fixed_matmul.sv
// rtl/streaming_fixed_matmul.sv - handshaked multi-cycle fixed-point matrix multiplier (out = a @ b)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only, low while in reset)
//   a_data     a (M x N), row-major, element (i,j) at [(i*N+j)*A_WIDTH +: A_WIDTH]
//   b_data     b (N x K), row-major, element (j,k) at [(j*K+k)*B_WIDTH +: B_WIDTH]
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out_data   out (M x K), row-major, element (i,k) at [(i*K+k)*OUT_WIDTH +: OUT_WIDTH]
//   busy       high in any state other than IDLE
module streaming_fixed_matmul #(
    parameter int M              = 2,
    parameter int N              = 2,
    parameter int K              = 2,
    parameter int A_WIDTH        = 8,
    parameter int A_FRAC_WIDTH   = 1,
    parameter int B_WIDTH        = 8,
    parameter int B_FRAC_WIDTH   = 1,
    parameter int OUT_WIDTH      = 16,
    parameter int OUT_FRAC_WIDTH = 1,
    parameter int ROUND_MODE     = 1,
    parameter int SATURATE       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [M*N*A_WIDTH-1:0]       a_data,
    input  logic [N*K*B_WIDTH-1:0]       b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M*K*OUT_WIDTH-1:0]     out_data,
    output logic                         busy
);

    localparam int PROD_W    = A_WIDTH + B_WIDTH;
    localparam int PROD_FRAC = A_FRAC_WIDTH + B_FRAC_WIDTH;
    localparam int ACC_W     = PROD_W + $clog2(N) + 1;
    localparam int SHIFT     = PROD_FRAC - OUT_FRAC_WIDTH;
    localparam int RSH       = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH       = (SHIFT < 0) ? -SHIFT : 0;
    // One guard bit above the left-shifted accumulator so the rounding add never wraps.
    localparam int EXT_W     = ACC_W + LSH + 1;
    // Comparison width covers both the aligned value and the output range.
    localparam int CMP_W     = ((EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH) + 1;
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;

    // Half an output LSB expressed in accumulator units; zero when no right shift or truncating.
    localparam logic signed [EXT_W-1:0] RND_ADD =
        (ROUND_MODE != 0) ? ((EXT_W'(1) << RSH) >> 1) : '0;
    localparam logic signed [CMP_W-1:0] SAT_MAX =
        {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN =
        {{(CMP_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ROUND  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [M*N*A_WIDTH-1:0]       a_reg;
    logic [N*K*B_WIDTH-1:0]       b_reg;
    logic [CNT_W-1:0]             j_cnt;
    logic signed [ACC_W-1:0]      acc  [M][K];
    logic signed [A_WIDTH-1:0]    a_col [M];
    logic signed [B_WIDTH-1:0]    b_row [K];
    logic signed [PROD_W-1:0]     prod [M][K];
    logic [M*K*OUT_WIDTH-1:0]     rounded;
    logic signed [EXT_W-1:0]      ext_val;
    logic signed [EXT_W-1:0]      aligned;
    logic signed [CMP_W-1:0]      wide;
    logic                         accept;
    logic                         last_j;

    // in_ready is gated by rst so it reads low for the whole reset assertion.
    assign in_ready  = rst && (state == IDLE);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_j    = (j_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = ACCUM;
            ACCUM:   if (last_j)    state_next = ROUND;
            ROUND:                  state_next = OUTPUT;
            OUTPUT:  if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Column j of a and row j of b feed all M*K MACs in the current accumulation cycle.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            a_col[i] = a_reg[(i*N + int'(j_cnt))*A_WIDTH +: A_WIDTH];
        end
        for (int k = 0; k < K; k++) begin
            b_row[k] = b_reg[(int'(j_cnt)*K + k)*B_WIDTH +: B_WIDTH];
        end
        for (int i = 0; i < M; i++) begin
            for (int k = 0; k < K; k++) begin
                prod[i][k] = a_col[i] * b_row[k];
            end
        end
    end

    // Align each accumulator to the output fraction, then clamp or wrap.
    always_comb begin
        rounded = '0;
        ext_val = '0;
        aligned = '0;
        wide    = '0;
        for (int i = 0; i < M; i++) begin
            for (int k = 0; k < K; k++) begin
                ext_val = EXT_W'(acc[i][k]);
                aligned = (ext_val + RND_ADD) >>> RSH;
                aligned = aligned <<< LSH;
                wide    = CMP_W'(aligned);
                if (SATURATE != 0) begin
                    if (wide > SAT_MAX) begin
                        rounded[(i*K+k)*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
                    end else if (wide < SAT_MIN) begin
                        rounded[(i*K+k)*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
                    end else begin
                        rounded[(i*K+k)*OUT_WIDTH +: OUT_WIDTH] = wide[OUT_WIDTH-1:0];
                    end
                end else begin
                    rounded[(i*K+k)*OUT_WIDTH +: OUT_WIDTH] = wide[OUT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            j_cnt    <= '0;
            out_data <= '0;
            for (int i = 0; i < M; i++) begin
                for (int k = 0; k < K; k++) begin
                    acc[i][k] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a_data;
                        b_reg <= b_data;
                        j_cnt <= '0;
                        for (int i = 0; i < M; i++) begin
                            for (int k = 0; k < K; k++) begin
                                acc[i][k] <= '0;
                            end
                        end
                    end
                end
                ACCUM: begin
                    for (int i = 0; i < M; i++) begin
                        for (int k = 0; k < K; k++) begin
                            acc[i][k] <= acc[i][k] + ACC_W'(prod[i][k]);
                        end
                    end
                    j_cnt <= last_j ? '0 : j_cnt + CNT_W'(1);
                end
                ROUND: begin
                    out_data <= rounded;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_streaming_fixed_matmul.sv
// tb/tb_streaming_fixed_matmul.sv - self-checking bench for streaming_fixed_matmul
module tb_streaming_fixed_matmul;

    localparam int M2 = 3, N2 = 5, K2 = 4, OW2 = 12;
    localparam int AW2 = 120, BW2 = 160, RW2 = 144;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Three 2x2x2 instances driven in lockstep with different output formats.
    logic        in_valid_s = 1'b0, out_ready_s = 1'b0;
    logic [31:0] a_s = '0, b_s = '0;
    logic        in_ready0, in_ready1, in_ready3;
    logic        out_valid0, out_valid1, out_valid3;
    logic        busy0, busy1, busy3;
    logic [63:0] out_data0;
    logic [31:0] out_data1, out_data3;

    // 3x5x4 instance for reset and random traffic.
    logic           in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [AW2-1:0] a2 = '0;
    logic [BW2-1:0] b2 = '0;
    logic           in_ready2, out_valid2, busy2;
    logic [RW2-1:0] out_data2;

    int errors = 0;
    int checks = 0;

    streaming_fixed_matmul #(.OUT_WIDTH(16), .ROUND_MODE(1), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready0),
        .a_data(a_s), .b_data(b_s), .out_valid(out_valid0), .out_ready(out_ready_s),
        .out_data(out_data0), .busy(busy0));

    streaming_fixed_matmul #(.OUT_WIDTH(8), .ROUND_MODE(0), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready1),
        .a_data(a_s), .b_data(b_s), .out_valid(out_valid1), .out_ready(out_ready_s),
        .out_data(out_data1), .busy(busy1));

    streaming_fixed_matmul #(.OUT_WIDTH(8), .ROUND_MODE(1), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready3),
        .a_data(a_s), .b_data(b_s), .out_valid(out_valid3), .out_ready(out_ready_s),
        .out_data(out_data3), .busy(busy3));

    streaming_fixed_matmul #(.M(M2), .N(N2), .K(K2), .A_FRAC_WIDTH(3), .OUT_WIDTH(OW2),
                             .ROUND_MODE(1), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_data(a2), .b_data(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .busy(busy2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Scale an exact product-sum (s fractional bits above output) to the output format.
    function automatic longint quant(input longint acc, input int s, input int rm,
                                     input int sat, input int ow);
        longint v, d, m, hi, lo;
        if (s > 0) begin
            d = longint'(1) << s;
            v = floor_div(acc + ((rm != 0) ? d / 2 : 0), d);
        end else begin
            v = acc * (longint'(1) << (-s));
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        if (sat != 0) begin
            if (v > hi) v = hi;
            else if (v < lo) v = lo;
        end else begin
            m = longint'(1) << ow;
            v = ((v % m) + m) % m;
            if (v > hi) v = v - m;
        end
        return v;
    endfunction

    function automatic longint small_acc(input int av[4], input int bv[4], input int i, input int k);
        longint s;
        s = 0;
        for (int j = 0; j < 2; j++) s += longint'(av[i*2+j]) * longint'(bv[j*2+k]);
        return s;
    endfunction

    function automatic logic [RW2-1:0] model2(input logic [AW2-1:0] a, input logic [BW2-1:0] b);
        logic [RW2-1:0] r;
        longint s, v;
        r = '0;
        for (int i = 0; i < M2; i++) begin
            for (int k = 0; k < K2; k++) begin
                s = 0;
                for (int j = 0; j < N2; j++)
                    s += longint'($signed(a[(i*N2+j)*8 +: 8])) * longint'($signed(b[(j*K2+k)*8 +: 8]));
                v = quant(s, 3, 1, 1, OW2);
                r[(i*K2+k)*OW2 +: OW2] = v[OW2-1:0];
            end
        end
        return r;
    endfunction

    task automatic run_small(input string tag, input int av[4], input int bv[4], input bit bp);
        int lat;
        logic [63:0] held;
        longint acc;
        for (int e = 0; e < 4; e++) begin
            a_s[e*8 +: 8] = av[e][7:0];
            b_s[e*8 +: 8] = bv[e][7:0];
        end
        chk({tag, "_in_ready"}, in_ready0 & in_ready1 & in_ready3, 1);
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        chk({tag, "_busy"}, busy0 & busy1 & busy3, 1);
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_valid_all"}, out_valid1 & out_valid3, 1);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                acc = small_acc(av, bv, i, k);
                chk($sformatf("%s_d0_%0d%0d", tag, i, k), $signed(out_data0[(i*2+k)*16 +: 16]), quant(acc, 1, 1, 1, 16));
                chk($sformatf("%s_d1_%0d%0d", tag, i, k), $signed(out_data1[(i*2+k)*8 +: 8]), quant(acc, 1, 0, 1, 8));
                chk($sformatf("%s_d3_%0d%0d", tag, i, k), $signed(out_data3[(i*2+k)*8 +: 8]), quant(acc, 1, 1, 0, 8));
            end
        end
        if (bp) begin
            held = out_data0;
            for (int c = 0; c < 10; c++) begin
                in_valid_s = 1'b1;
                a_s = $urandom;
                b_s = $urandom;
                @(posedge clk); #1;
                chk($sformatf("%s_bp_hold_%0d", tag, c), out_data0, held);
                chk($sformatf("%s_bp_ready_%0d", tag, c), in_ready0 | in_ready1 | in_ready3, 0);
                chk($sformatf("%s_bp_valid_%0d", tag, c), out_valid0, 1);
            end
            in_valid_s = 1'b0;
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        chk({tag, "_done_valid"}, out_valid0 | out_valid1 | out_valid3, 0);
        chk({tag, "_done_ready"}, in_ready0 & in_ready1 & in_ready3, 1);
        chk({tag, "_done_busy"}, busy0 | busy1 | busy3, 0);
    endtask

    task automatic rand_ops2();
        for (int w = 0; w < AW2 / 8; w++) a2[w*8 +: 8] = 8'($urandom);
        for (int w = 0; w < BW2 / 8; w++) b2[w*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int va[4], vb[4];
        int lat, sent, got, cyc;
        logic [RW2-1:0] exp2;
        logic [RW2-1:0] q[$];

        #2;
        chk("rst_in_ready", {in_ready0, in_ready1, in_ready3, in_ready2}, 0);
        chk("rst_out_valid", {out_valid0, out_valid1, out_valid3, out_valid2}, 0);
        chk("rst_busy", {busy0, busy1, busy3, busy2}, 0);
        chk("rst_out_data0", out_data0, 0);
        chk("rst_out_data2", |out_data2, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {in_ready0, in_ready1, in_ready3, in_ready2}, 4'hf);

        va = '{2, 4, 6, 8};   vb = '{2, 0, 0, 2};
        run_small("identity", va, vb, 1'b0);
        chk("identity_lit_d0", out_data0, 64'h0008_0006_0004_0002);
        chk("identity_lit_d1", out_data1, 32'h08060402);

        va = '{1, 0, 0, 0};   vb = '{1, 0, 0, 0};
        run_small("round_pos", va, vb, 1'b0);
        chk("round_pos_lit_d0", out_data0, 64'h1);
        chk("round_pos_lit_d1", out_data1, 32'h0);

        va = '{-1, 0, 0, 0};  vb = '{1, 0, 0, 0};
        run_small("round_neg", va, vb, 1'b0);
        chk("round_neg_lit_d0", out_data0, 64'h0);
        chk("round_neg_lit_d1", out_data1, 32'h000000ff);

        va = '{127, 127, 127, 127};  vb = '{127, 127, 127, 127};
        run_small("sat_pos", va, vb, 1'b0);
        chk("sat_pos_lit_d1", out_data1, 32'h7f7f7f7f);
        chk("sat_pos_lit_d3", out_data3, 32'h01010101);

        va = '{-128, -128, -128, -128};  vb = '{127, 127, 127, 127};
        run_small("sat_neg", va, vb, 1'b0);
        chk("sat_neg_lit_d1", out_data1, 32'h80808080);
        chk("sat_neg_lit_d0", out_data0, 64'hc080_c080_c080_c080);

        va = '{3, -5, 7, 9};  vb = '{-2, 11, 4, -6};
        run_small("backpressure", va, vb, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int e = 0; e < 4; e++) begin
                va[e] = int'($urandom_range(0, 255)) - 128;
                vb[e] = int'($urandom_range(0, 255)) - 128;
            end
            run_small($sformatf("rnd_small%0d", t), va, vb, 1'b0);
        end

        // Reset in the middle of accumulation (j=1) on the 3x5x4 instance.
        @(negedge clk);
        rand_ops2();
        in_valid2 = 1'b1;
        chk("abort_in_ready", in_ready2, 1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", busy2, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy2, 0);
        chk("abort_in_ready_low", in_ready2, 0);
        chk("abort_out_valid", out_valid2, 0);
        chk("abort_out_data", |out_data2, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_valid", out_valid2, 0);
        rst = 1'b1;

        @(negedge clk);
        rand_ops2();
        exp2 = model2(a2, b2);
        in_valid2 = 1'b1;
        chk("after_abort_in_ready", in_ready2, 1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        rand_ops2();
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("after_abort_latency", lat, N2 + 1);
        for (int e = 0; e < M2 * K2; e++)
            chk($sformatf("after_abort_e%0d", e), $signed(out_data2[e*OW2 +: OW2]), $signed(exp2[e*OW2 +: OW2]));
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        chk("after_abort_done", out_valid2, 0);

        // Random traffic: handshakes are decided at the falling edge for the coming rising edge.
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid2 = (sent < 200) && ($urandom_range(0, 3) != 0);
            rand_ops2();
            out_ready2 = ($urandom_range(0, 2) != 0);
            if (in_valid2 && in_ready2) begin
                q.push_back(model2(a2, b2));
                sent++;
            end
            if (out_valid2 && out_ready2) begin
                chk($sformatf("rand_unexpected_%0d", got), q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp2 = q.pop_front();
                    for (int e = 0; e < M2 * K2; e++)
                        chk($sformatf("rand%0d_e%0d", got, e), $signed(out_data2[e*OW2 +: OW2]), $signed(exp2[e*OW2 +: OW2]));
                end
                got++;
            end
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b0;
        chk("rand_count", got, 200);
        chk("rand_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
